// File: rtl/c_stream_collector.sv
// c_stream_collector: output stage behind the compute wrapper.
// Buffers result beats in a small FIFO and regenerates tlast from the
// configured frame length. It also flags misplaced upstream tlast
// markers and counts completed frames.
module c_stream_collector #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_axis_c_tdata,
   input  logic              s_axis_c_tvalid,
   output logic              s_axis_c_tready,
   input  logic              s_axis_c_tlast,
   output logic [DATA_W-1:0] m_axis_r_tdata,
   output logic              m_axis_r_tvalid,
   input  logic              m_axis_r_tready,
   output logic              m_axis_r_tlast,
   input  logic [15:0]       cfg_beats,
   output logic              frame_done,
   output logic              err_last,
   output logic [15:0]       frame_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   // Each entry holds {regenerated last, data}
   logic [DATA_W:0] mem_q [DEPTH];
   logic [AW-1:0]   wrPtr_q;
   logic [AW-1:0]   rdPtr_q;
   logic [AW:0]     count_q;
   logic [AW:0]     count_d;
   logic            ready_q;
   logic [15:0]     beatCnt_q;
   logic [15:0]     frameLen_q;
   logic            frameDone_q;
   logic            errLast_q;
   logic [15:0]     frameCount_q;

   logic            push;
   logic            pop;
   logic [15:0]     cfgLen;
   logic [15:0]     curLen;
   logic            expLast;
   logic [DATA_W:0] rdEntry;

   assign push = s_axis_c_tvalid && ready_q;
   assign pop  = (count_q != '0) && m_axis_r_tready;

   // A zero length is treated as a one-beat frame; the first beat of a
   // frame uses the live config, later beats use the latched length.
   assign cfgLen  = (cfg_beats == 16'd0) ? 16'd1 : cfg_beats;
   assign curLen  = (beatCnt_q == 16'd0) ? cfgLen : frameLen_q;
   assign expLast = (beatCnt_q == (curLen - 16'd1));

   // Next occupancy level from this cycle's push and pop
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage; contents need no reset because outputs are gated by valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= {expLast, s_axis_c_tdata};
      end
   end

   // Pointers, occupancy and the registered upstream ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_d;
         ready_q <= (count_d < FULL_LEVEL);
      end
   end

   // Frame position tracking, completion pulse/counter and tlast checking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beatCnt_q    <= '0;
         frameLen_q   <= '0;
         frameDone_q  <= 1'b0;
         errLast_q    <= 1'b0;
         frameCount_q <= '0;
      end else begin
         frameDone_q <= push && expLast;
         errLast_q   <= push && (s_axis_c_tlast != expLast);
         if (push) begin
            if (beatCnt_q == 16'd0) begin
               frameLen_q <= cfgLen;
            end
            if (expLast) begin
               beatCnt_q    <= '0;
               frameCount_q <= frameCount_q + 16'd1;
            end else begin
               beatCnt_q <= beatCnt_q + 16'd1;
            end
         end
      end
   end

   assign rdEntry         = mem_q[rdPtr_q];
   assign m_axis_r_tvalid = (count_q != '0);
   assign m_axis_r_tdata  = m_axis_r_tvalid ? rdEntry[DATA_W-1:0] : '0;
   assign m_axis_r_tlast  = m_axis_r_tvalid && rdEntry[DATA_W];
   assign s_axis_c_tready = ready_q;
   assign frame_done      = frameDone_q;
   assign err_last        = errLast_q;
   assign frame_count     = frameCount_q;

endmodule

// File: tb/tb_c_stream_collector.sv
// Directed testbench for c_stream_collector (DATA_W=32, DEPTH=8).
module tb_c_stream_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] sTdata;
   logic        sTvalid;
   logic        sTready;
   logic        sTlast;
   logic [31:0] mTdata;
   logic        mTvalid;
   logic        mReady;
   logic        mTlast;
   logic [15:0] cfgBeats;
   logic        frameDone;
   logic        errLast;
   logic [15:0] frameCount;

   int checkCount = 0;
   int passCount  = 0;
   int doneCnt    = 0;
   int errCnt     = 0;
   logic [31:0] outData [$];
   logic        outLast [$];

   c_stream_collector #(.DATA_W(32), .DEPTH(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_axis_c_tdata  (sTdata),
      .s_axis_c_tvalid (sTvalid),
      .s_axis_c_tready (sTready),
      .s_axis_c_tlast  (sTlast),
      .m_axis_r_tdata  (mTdata),
      .m_axis_r_tvalid (mTvalid),
      .m_axis_r_tready (mReady),
      .m_axis_r_tlast  (mTlast),
      .cfg_beats       (cfgBeats),
      .frame_done      (frameDone),
      .err_last        (errLast),
      .frame_count     (frameCount)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Record every beat the output stream hands over
   always @(posedge clk) begin
      if (rst_n && mTvalid && mReady) begin
         outData.push_back(mTdata);
         outLast.push_back(mTlast);
      end
   end

   // Count completion and error pulses
   always @(negedge clk) begin
      if (frameDone) doneCnt++;
      if (errLast) errCnt++;
   end

   // Hard stop in case something stalls forever
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
   endtask

   task automatic resetDut();
      rst_n    = 1'b0;
      sTvalid  = 1'b0;
      sTlast   = 1'b0;
      sTdata   = '0;
      mReady   = 1'b0;
      cfgBeats = 16'd4;
      repeat (2) @(negedge clk);
      doneCnt = 0;
      errCnt  = 0;
      outData.delete();
      outLast.delete();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", sTready, 1);
   endtask

   // Present one beat at a falling edge and hold it until accepted;
   // returns at the falling edge right after the accepting rising edge.
   task automatic applyStimulus(input logic [31:0] d, input logic l);
      bit acc;
      acc     = 1'b0;
      sTvalid = 1'b1;
      sTdata  = d;
      sTlast  = l;
      for (int i = 0; i < 40 && !acc; i++) begin
         acc = sTready;
         @(negedge clk);
      end
      if (!acc) checkOutput("send_timeout", 0, 1);
   endtask

   task automatic goIdle(input int n);
      sTvalid = 1'b0;
      sTlast  = 1'b0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      int accepted;
      bit acc;
      logic [31:0] d3 [4];
      logic        l3 [4];
      logic        e3 [4];
      logic        l5 [6];

      // Reset values
      rst_n = 1'b0;
      sTvalid = 1'b0; sTlast = 1'b0; sTdata = '0; mReady = 1'b0; cfgBeats = 16'd4;
      #2;
      checkOutput("rst_ready", sTready, 0);
      checkOutput("rst_valid", mTvalid, 0);
      checkOutput("rst_count", frameCount, 0);

      // Single 4-beat frame with free-flowing output
      resetDut();
      mReady = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(k, k == 4);
         checkOutput("t1_valid", mTvalid, 1);
         checkOutput("t1_data", mTdata, k);
         checkOutput("t1_last", mTlast, k == 4);
         checkOutput("t1_done", frameDone, k == 4);
      end
      goIdle(3);
      checkOutput("t1_done_cnt", doneCnt, 1);
      checkOutput("t1_frame_count", frameCount, 1);
      checkOutput("t1_err_cnt", errCnt, 0);
      checkOutput("t1_out_size", outData.size(), 4);

      // Backpressure: only DEPTH beats fit, ready returns right after first pop
      resetDut();
      cfgBeats = 16'd16;
      accepted = 0;
      sTvalid  = 1'b1;
      sTdata   = 32'd100;
      for (int i = 0; i < 10; i++) begin
         acc = sTready;
         @(negedge clk);
         if (acc) begin
            accepted++;
            sTdata = sTdata + 32'd1;
         end
      end
      checkOutput("t2_accepted", accepted, 8);
      checkOutput("t2_ready_full", sTready, 0);
      checkOutput("t2_head", mTdata, 100);
      sTvalid = 1'b0;
      mReady  = 1'b1;
      @(negedge clk);
      checkOutput("t2_ready_back", sTready, 1);
      checkOutput("t2_second", mTdata, 101);
      goIdle(10);
      checkOutput("t2_out_size", outData.size(), 8);
      for (int i = 0; i < 8; i++) checkOutput("t2_order", outData[i], 100 + i);
      checkOutput("t2_empty", mTvalid, 0);

      // Misplaced upstream tlast
      resetDut();
      mReady = 1'b1;
      d3 = '{32'd11, 32'd12, 32'd13, 32'd14};
      l3 = '{1'b0, 1'b1, 1'b0, 1'b0};
      e3 = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         applyStimulus(d3[k], l3[k]);
         checkOutput("t3_err", errLast, e3[k]);
      end
      goIdle(3);
      checkOutput("t3_err_cnt", errCnt, 2);
      checkOutput("t3_frame_count", frameCount, 1);
      checkOutput("t3_out_size", outLast.size(), 4);
      for (int i = 0; i < 4; i++) checkOutput("t3_out_last", outLast[i], i == 3);

      // Zero length behaves as one-beat frames
      resetDut();
      mReady   = 1'b1;
      cfgBeats = 16'd0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(21 + k, 1'b1);
         checkOutput("t4_done", frameDone, 1);
         checkOutput("t4_err", errLast, 0);
         checkOutput("t4_last", mTlast, 1);
      end
      goIdle(3);
      checkOutput("t4_done_cnt", doneCnt, 3);
      checkOutput("t4_frame_count", frameCount, 3);

      // Length change mid-frame only applies from the next frame
      resetDut();
      mReady = 1'b1;
      cfgBeats = 16'd4;
      l5 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      applyStimulus(31, l5[0]);
      cfgBeats = 16'd2;
      for (int k = 1; k < 6; k++) applyStimulus(31 + k, l5[k]);
      goIdle(3);
      checkOutput("t5_out_size", outLast.size(), 6);
      for (int i = 0; i < 6; i++) checkOutput("t5_out_last", outLast[i], l5[i]);
      checkOutput("t5_frame_count", frameCount, 2);
      checkOutput("t5_err_cnt", errCnt, 0);

      // Asynchronous reset with beats buffered
      resetDut();
      cfgBeats = 16'd4;
      for (int k = 0; k < 5; k++) applyStimulus(41 + k, k == 3);
      goIdle(1);
      checkOutput("t6_pre_count", frameCount, 1);
      checkOutput("t6_pre_valid", mTvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", mTvalid, 0);
      checkOutput("t6_rst_data", mTdata, 0);
      checkOutput("t6_rst_last", mTlast, 0);
      checkOutput("t6_rst_ready", sTready, 0);
      checkOutput("t6_rst_count", frameCount, 0);
      repeat (2) @(negedge clk);
      outData.delete();
      outLast.delete();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t6_empty", mTvalid, 0);
      checkOutput("t6_ready", sTready, 1);
      mReady = 1'b1;
      for (int k = 0; k < 4; k++) applyStimulus(51 + k, k == 3);
      goIdle(3);
      checkOutput("t6_frame_count", frameCount, 1);
      checkOutput("t6_out_size", outData.size(), 4);
      checkOutput("t6_first", outData[0], 51);
      checkOutput("t6_last_flag", outLast[3], 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
